vnu_msg_sat_fifo: RTL

VNU_MSG_SAT_FIFO -- requirements
Module: vnu_msg_sat_fifo

---
 rtl/vnu_msg_sat_fifo_pkg.sv | 22 ++
 rtl/vnu_msg_sat_fifo_if.sv | 31 +++
 rtl/vnu_msg_sat_fifo_sat.sv | 26 ++
 rtl/vnu_msg_sat_fifo.sv | 84 ++++++++
 4 files changed

// File: rtl/vnu_msg_sat_fifo_pkg.sv
// Shared widths, message types and FIFO entry layout for the VNU->CNU message FIFO.
package vnu_pkg;
   localparam int DEF_W_IN  = 10;
   localparam int DEF_W_OUT = 6;
   localparam int DEF_DEPTH = 4;
   localparam int MSG_MAX   = 31;

   typedef logic signed [DEF_W_IN-1:0]  msg_in_t;
   typedef logic signed [DEF_W_OUT-1:0] msg_out_t;

   // sat[k] belongs to lane k, so a literal like 4'b1101 reads lane 0 first
   typedef struct packed {
      msg_out_t [0:3] msg;
      logic           hard;
      logic [0:3]     sat;
   } entry_t;

   // Largest symmetric magnitude for a w-bit two's complement message
   function automatic int msg_max(input int w);
      return (1 << (w - 1)) - 1;
   endfunction
endpackage

// File: rtl/vnu_msg_sat_fifo_if.sv
// Handshake bus between the shuffled VNU (producer) and the check-node side (consumer).
interface vnu_msg_sat_fifo_if
   import vnu_pkg::*;
#(
   parameter int W_IN  = DEF_W_IN,
   parameter int W_OUT = DEF_W_OUT,
   parameter int DEPTH = DEF_DEPTH
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic                    i_valid;
   logic                    o_ready;
   logic [0:4][W_IN-1:0]    i_data;
   logic                    o_valid;
   logic                    i_ready;
   logic [0:3][W_OUT-1:0]   o_data;
   logic                    o_hard;
   logic [0:3]              o_sat;
   logic [15:0]             o_sat_cnt;
   logic [LW-1:0]           o_level;

   modport slave (
      input  i_valid, i_data, i_ready,
      output o_ready, o_valid, o_data, o_hard, o_sat, o_sat_cnt, o_level
   );

   modport master (
      output i_valid, i_data, i_ready,
      input  o_ready, o_valid, o_data, o_hard, o_sat, o_sat_cnt, o_level
   );
endinterface

// File: rtl/vnu_msg_sat_fifo_sat.sv
// Symmetric W_IN->W_OUT saturator; the most negative code is clipped too so |y| <= MAX.
module msg_sat
   import vnu_pkg::*;
#(
   parameter int W_IN  = DEF_W_IN,
   parameter int W_OUT = DEF_W_OUT
) (
   input  logic signed [W_IN-1:0]  x,
   output logic        [W_OUT-1:0] y,
   output logic                    clip
);
   localparam logic signed [W_IN-1:0] HI = W_IN'(msg_max(W_OUT));
   localparam logic signed [W_IN-1:0] LO = -HI;

   always_comb begin
      y    = x[W_OUT-1:0];
      clip = 1'b0;
      if (x > HI) begin
         y    = HI[W_OUT-1:0];
         clip = 1'b1;
      end else if (x < LO) begin
         y    = LO[W_OUT-1:0];
         clip = 1'b1;
      end
   end
endmodule

// File: rtl/vnu_msg_sat_fifo.sv
// Show-ahead message FIFO: saturates lanes 0..3 and keeps only the posterior sign on write.
module vnu_msg_sat_fifo
   import vnu_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int W_IN  = DEF_W_IN,
   parameter int W_OUT = DEF_W_OUT
) (
   input  logic                clk,
   input  logic                i_rst,
   vnu_msg_sat_fifo_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef struct packed {
      logic [0:3][W_OUT-1:0] msg;
      logic                  hard;
      logic [0:3]            sat;
   } slot_t;

   logic [0:3][W_OUT-1:0] sat_msg;
   logic [0:3]            sat_clip;
   slot_t                 wr_slot;
   slot_t                 mem [DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [LW-1:0]         level;
   logic [15:0]           sat_cnt;
   logic                  full, empty, push, pop;

   for (genvar k = 0; k < 4; k++) begin : g_sat
      msg_sat #(.W_IN(W_IN), .W_OUT(W_OUT)) u_sat (
         .x    (bus.i_data[k]),
         .y    (sat_msg[k]),
         .clip (sat_clip[k])
      );
   end

   always_comb begin
      wr_slot      = '0;
      wr_slot.msg  = sat_msg;
      wr_slot.hard = bus.i_data[4][W_IN-1];
      wr_slot.sat  = sat_clip;
   end

   // Flags come from the level register only, so ready never depends on i_ready
   assign full  = (level == LW'(DEPTH));
   assign empty = (level == '0);
   assign push  = bus.i_valid && !full;
   assign pop   = bus.i_ready && !empty;

   always_ff @(posedge clk) begin
      if (i_rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         sat_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
         if (push && (|sat_clip) && (sat_cnt != 16'hFFFF))
            sat_cnt <= sat_cnt + 16'd1;
      end
   end

   // Storage is not reset; the pointers alone define what is valid
   always_ff @(posedge clk) begin
      if (push && !i_rst)
         mem[wr_ptr] <= wr_slot;
   end

   assign bus.o_ready   = !full;
   assign bus.o_valid   = !empty;
   assign bus.o_data    = mem[rd_ptr].msg;
   assign bus.o_hard    = mem[rd_ptr].hard;
   assign bus.o_sat     = mem[rd_ptr].sat;
   assign bus.o_sat_cnt = sat_cnt;
   assign bus.o_level   = level;
endmodule
